vga_timing_gen: RTL

Parametrised VGA raster timing generator; successor to the fixed 640x480 `vga` block. It divides the system clock down to a pixel tick and produces sync, display-enable, raster position and a look-ahead fetch position. The look-ahead lets VRAM/CRAM reads in `vdp_disp_interface` complete before the pixel is displayed. It sits between the system clock domain and the VGA pins in the VDP display path.

---
 rtl/vga_timing_gen.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing (sync, display enable, position, look-ahead fetch position); optional frame counter under VGA_FRAME_CNT_EN.
// Latency: every output is registered and describes the position reached on the same clk edge that raises pix_tick.
// Backpressure: none; en=0 freezes divider, counters and outputs, with pix_tick/line_start/frame_start held low.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int CLK_DIV    = 4,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int FETCH_LEAD = 2,
    parameter int COL_W      = 10,
    parameter int ROW_W      = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             pix_tick,
    output logic             HSync,
    output logic             VSync,
    output logic             disp_en,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             line_start,
    output logic             frame_start,
    output logic             fetch_en,
    output logic [COL_W-1:0] fetch_col,
    output logic [ROW_W-1:0] fetch_row,
    output logic [15:0]      frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int V_W     = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [H_W-1:0]   H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0]   V_LAST   = V_W'(V_TOTAL - 1);

    // One extra bit so that region bounds equal to the axis total still fit.
    localparam logic [H_W:0] H_TOTAL_X  = (H_W + 1)'(H_TOTAL);
    localparam logic [H_W:0] LEAD_X     = (H_W + 1)'(FETCH_LEAD);
    localparam logic [H_W:0] H_ACT_X    = (H_W + 1)'(H_ACTIVE);
    localparam logic [H_W:0] HS_START_X = (H_W + 1)'(H_ACTIVE + H_FP);
    localparam logic [H_W:0] HS_STOP_X  = (H_W + 1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_W:0] V_ACT_X    = (V_W + 1)'(V_ACTIVE);
    localparam logic [V_W:0] VS_START_X = (V_W + 1)'(V_ACTIVE + V_FP);
    localparam logic [V_W:0] VS_STOP_X  = (V_W + 1)'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div;
    logic [H_W-1:0]   h;
    logic [V_W-1:0]   v;

    logic             tick;
    logic [H_W-1:0]   h_nxt;
    logic [V_W-1:0]   v_nxt;
    logic [H_W:0]     f_sum;
    logic [H_W-1:0]   fh_nxt;
    logic [V_W-1:0]   fv_nxt;
    logic             frame_hit;

    logic             de_nxt;
    logic             fe_nxt;
    logic             hs_act;
    logic             vs_act;

    // Pixel tick fires on the last divider phase while running.
    assign tick = en && (div == DIV_LAST);

    // Next raster position and the look-ahead position FETCH_LEAD ticks beyond it.
    always_comb begin
        h_nxt  = h + H_W'(1);
        v_nxt  = v;
        if (h == H_LAST) begin
            h_nxt = '0;
            v_nxt = (v == V_LAST) ? '0 : v + V_W'(1);
        end
        f_sum  = {1'b0, h_nxt} + LEAD_X;
        fh_nxt = f_sum[H_W-1:0];
        fv_nxt = v_nxt;
        // Lead never exceeds one line, so at most one horizontal wrap is possible.
        if (f_sum >= H_TOTAL_X) begin
            fh_nxt = H_W'(f_sum - H_TOTAL_X);
            fv_nxt = (v_nxt == V_LAST) ? '0 : v_nxt + V_W'(1);
        end
    end

    // Region decode of the next-state positions so registered outputs carry no lag.
    always_comb begin
        de_nxt = ({1'b0, h_nxt} < H_ACT_X) && ({1'b0, v_nxt} < V_ACT_X);
        fe_nxt = ({1'b0, fh_nxt} < H_ACT_X) && ({1'b0, fv_nxt} < V_ACT_X);
        hs_act = ({1'b0, h_nxt} >= HS_START_X) && ({1'b0, h_nxt} < HS_STOP_X);
        vs_act = ({1'b0, v_nxt} >= VS_START_X) && ({1'b0, v_nxt} < VS_STOP_X);
    end

    assign frame_hit = tick && (h_nxt == '0) && (v_nxt == '0);

    // Divider, raster counters and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div         <= '0;
            h           <= H_LAST;
            v           <= V_LAST;
            pix_tick    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            HSync       <= ~HS_POL;
            VSync       <= ~VS_POL;
            disp_en     <= 1'b0;
            col         <= '0;
            row         <= '0;
            fetch_en    <= 1'b0;
            fetch_col   <= '0;
            fetch_row   <= '0;
        end else begin
            pix_tick    <= tick;
            line_start  <= tick && (h_nxt == '0);
            frame_start <= frame_hit;
            if (en) begin
                div <= tick ? '0 : div + DIV_W'(1);
            end
            if (tick) begin
                h         <= h_nxt;
                v         <= v_nxt;
                HSync     <= hs_act ? HS_POL : ~HS_POL;
                VSync     <= vs_act ? VS_POL : ~VS_POL;
                disp_en   <= de_nxt;
                col       <= de_nxt ? COL_W'(h_nxt) : '0;
                row       <= de_nxt ? ROW_W'(v_nxt) : '0;
                fetch_en  <= fe_nxt;
                fetch_col <= fe_nxt ? COL_W'(fh_nxt) : '0;
                fetch_row <= fe_nxt ? ROW_W'(fv_nxt) : '0;
            end
        end
    end

`ifdef VGA_FRAME_CNT_EN
    // Frame counter advances on the edge that raises frame_start and wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (frame_hit) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`else
    assign frame_cnt = '0;
`endif

endmodule
